// File: rtl/softmax_mem_mp.sv
// One-write / NUM_RD-read word memory with lane write masks, pipelined reads and sticky OOB flag.
// Optional per-lane even parity is enabled with `define SOFTMAX_MEM_PARITY_EN.
module softmax_mem_mp #(
    parameter int DWIDTH     = 16,
    parameter int NUM        = 4,
    parameter int AWIDTH     = 10,
    parameter int MEM_SIZE   = 1024,
    parameter int NUM_RD     = 3,
    parameter int RD_LAT     = 1,
    parameter int READ_FIRST = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [AWIDTH-1:0]            wr_addr,
    input  logic [NUM-1:0]               wr_lane_en,
    input  logic [DWIDTH*NUM-1:0]        wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*AWIDTH-1:0]     rd_addr,
    output logic [NUM_RD*DWIDTH*NUM-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic                         oob_err,
    input  logic                         clr_err
`ifdef SOFTMAX_MEM_PARITY_EN
    ,
    output logic                         par_err,
    output logic [NUM-1:0]               par_lane
`endif
);
    localparam int W = DWIDTH * NUM;

    logic [W-1:0] ram [MEM_SIZE];

    function automatic logic in_range(input logic [AWIDTH-1:0] a);
        return 32'(a) < 32'(MEM_SIZE);
    endfunction

    function automatic logic [NUM-1:0] lane_par(input logic [W-1:0] word);
        logic [NUM-1:0] p;
        for (int i = 0; i < NUM; i++) p[i] = ^word[i*DWIDTH +: DWIDTH];
        return p;
    endfunction

    function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                           input logic [NUM-1:0] mask);
        logic [W-1:0] m;
        m = old_w;
        for (int i = 0; i < NUM; i++)
            if (mask[i]) m[i*DWIDTH +: DWIDTH] = new_w[i*DWIDTH +: DWIDTH];
        return m;
    endfunction

    logic wr_ok;
    assign wr_ok = wr_en && in_range(wr_addr);

    always_ff @(posedge clk) begin
        if (wr_ok)
            for (int i = 0; i < NUM; i++)
                if (wr_lane_en[i]) ram[wr_addr][i*DWIDTH +: DWIDTH] <= wr_data[i*DWIDTH +: DWIDTH];
    end

`ifdef SOFTMAX_MEM_PARITY_EN
    logic [NUM-1:0] par_mem [MEM_SIZE];
    logic [NUM-1:0] rd_mis  [NUM_RD];

    always @(posedge clk) begin
        if (wr_ok)
            for (int i = 0; i < NUM; i++)
                if (wr_lane_en[i]) par_mem[wr_addr][i] <= ^wr_data[i*DWIDTH +: DWIDTH];
    end
`endif

    logic [NUM_RD-1:0] rd_oob;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AWIDTH-1:0] a;
        logic              hit;
        logic [W-1:0]      old_word;

        assign a         = rd_addr[p*AWIDTH +: AWIDTH];
        assign hit       = in_range(a);
        assign old_word  = hit ? ram[a] : '0;
        assign rd_oob[p] = rd_en[p] && !hit;
`ifdef SOFTMAX_MEM_PARITY_EN
        assign rd_mis[p] = (rd_en[p] && hit) ? (par_mem[a] ^ lane_par(old_word)) : '0;
`endif

        if (RD_LAT == 0) begin : g_comb
            assign rd_data[p*W +: W] = old_word;
            assign rd_valid[p]       = rd_en[p];
        end else begin : g_pipe
            logic [W-1:0]      first_word;
            logic [W-1:0]      d_q [RD_LAT];
            logic [RD_LAT-1:0] v_q;

            // Write-first forwards the masked merge; read-first relies on NBA ordering.
            if (READ_FIRST == 0) begin : g_wf
                assign first_word = (wr_ok && wr_addr == a) ? merge(old_word, wr_data, wr_lane_en)
                                                            : old_word;
            end else begin : g_rf
                assign first_word = old_word;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v_q <= '0;
                    for (int i = 0; i < RD_LAT; i++) d_q[i] <= '0;
                end else begin
                    v_q[0] <= rd_en[p];
                    if (rd_en[p]) d_q[0] <= first_word;
                    for (int i = 1; i < RD_LAT; i++) begin
                        v_q[i] <= v_q[i-1];
                        if (v_q[i-1]) d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign rd_data[p*W +: W] = d_q[RD_LAT-1];
            assign rd_valid[p]       = v_q[RD_LAT-1];
        end
    end

    logic oob_now;
    assign oob_now = (wr_en && !in_range(wr_addr)) || (|rd_oob);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       oob_err <= 1'b0;
        else if (oob_now) oob_err <= 1'b1;
        else if (clr_err) oob_err <= 1'b0;
    end

`ifdef SOFTMAX_MEM_PARITY_EN
    logic [NUM-1:0] mis_any;

    always_comb begin
        mis_any = '0;
        for (int p = 0; p < NUM_RD; p++) mis_any = mis_any | rd_mis[p];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_err  <= 1'b0;
            par_lane <= '0;
        end else if (|mis_any) begin
            par_err  <= 1'b1;
            par_lane <= mis_any;
        end else if (clr_err) begin
            par_err  <= 1'b0;
        end
    end

    task automatic inject_par_flip(input logic [AWIDTH-1:0] addr, input int lane);
        par_mem[addr][lane] <= ~par_mem[addr][lane];
    endtask

    // Must follow any bulk preload of ram[].
    task automatic init_parity();
        for (int i = 0; i < MEM_SIZE; i++) par_mem[i] <= lane_par(ram[i]);
    endtask
`endif
endmodule
